// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: rotate/shift WIDTH-bit data by 0..WIDTH-1 positions in SHW
// registered stages. Stage k shifts by 2**k when its amount bit is set. A valid/ready handshake
// runs on both sides, and a combinational ready chain lets every stage move forward when the
// stages ahead of it have room.
//
// Parameters:
//   WIDTH       data width, a power of two in 4..64
//   SHW         log2(WIDTH), fixed: shift-amount width and stage count
// Ports:
//   clk         clock; all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous clear of all in-flight beats; blocks input for that cycle
//   in_valid    input beat offered
//   in_ready    input beat accepted when in_valid && in_ready
//   in_data     value to shift
//   in_amt      shift amount
//   in_mode     00 ROR, 01 ROL, 10 SRL, 11 SRA
//   out_valid   result beat valid
//   out_ready   downstream accepts result when out_valid && out_ready
//   out_data    shifted result
//   out_zero    (SHIFTER_STATUS_EN only) result is zero
//   out_carry   (SHIFTER_STATUS_EN only) last bit shifted out by SRL/SRA, else 0
//
// Build option: define SHIFTER_STATUS_EN to add the out_zero/out_carry status outputs.

module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_STATUS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two in 4..64");
  end

  typedef enum logic [1:0] {
    ModeRor = 2'b00,
    ModeRol = 2'b01,
    ModeSrl = 2'b10,
    ModeSra = 2'b11
  } mode_e;

  logic [SHW-1:0]            w_vld;
  logic [SHW-1:0]            w_en;
  logic [SHW-1:0][WIDTH-1:0] w_q_data;
  // Each stage stores its amount already shifted down, so the next stage always uses bit 0.
  logic [SHW-1:0][SHW-1:0]   w_q_amt;
  logic [SHW-1:0][1:0]       w_q_mode;
  logic                      w_accept;
`ifdef SHIFTER_STATUS_EN
  logic [SHW-1:0]            w_q_carry;
  logic                      r_zero;
`endif

  // Flush wins over a simultaneous input beat.
  assign in_ready = w_en[0] & ~flush;
  assign w_accept = in_valid & in_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned S = 2 ** k;

    logic [WIDTH-1:0] w_src_data;
    logic [WIDTH-1:0] w_shift_data;
    logic [SHW-1:0]   w_src_amt;
    logic [1:0]       w_src_mode;
    logic             w_src_vld;

    logic             r_vld;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_amt;
    logic [1:0]       r_mode;
`ifdef SHIFTER_STATUS_EN
    logic             w_src_carry;
    logic             w_shift_carry;
    logic             r_carry;
`endif

    if (k == 0) begin : g_src_in
      assign w_src_data  = in_data;
      assign w_src_amt   = in_amt;
      assign w_src_mode  = in_mode;
      assign w_src_vld   = w_accept;
`ifdef SHIFTER_STATUS_EN
      assign w_src_carry = 1'b0;
`endif
    end else begin : g_src_prev
      assign w_src_data  = w_q_data[k-1];
      assign w_src_amt   = w_q_amt[k-1];
      assign w_src_mode  = w_q_mode[k-1];
      assign w_src_vld   = w_vld[k-1];
`ifdef SHIFTER_STATUS_EN
      assign w_src_carry = w_q_carry[k-1];
`endif
    end

    always_comb begin
      w_shift_data = w_src_data;
      if (w_src_amt[0]) begin
        case (mode_e'(w_src_mode))
          ModeRor: w_shift_data = {w_src_data[S-1:0], w_src_data[WIDTH-1:S]};
          ModeRol: w_shift_data = {w_src_data[WIDTH-S-1:0], w_src_data[WIDTH-1:WIDTH-S]};
          ModeSrl: w_shift_data = {{S{1'b0}}, w_src_data[WIDTH-1:S]};
          ModeSra: w_shift_data = {{S{w_src_data[WIDTH-1]}}, w_src_data[WIDTH-1:S]};
          default: w_shift_data = w_src_data;
        endcase
      end
    end

`ifdef SHIFTER_STATUS_EN
    // Low amount bits are consumed first, so the last shifting stage drops in_data[amt-1].
    assign w_shift_carry = (w_src_amt[0] && w_src_mode[1]) ? w_src_data[S-1] : w_src_carry;
`endif

    // A stage may load when it or any stage ahead of it is empty, or the output drains.
    assign w_en[k] = out_ready | ~(&w_vld[SHW-1:k]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld   <= 1'b0;
        r_data  <= '0;
        r_amt   <= '0;
        r_mode  <= '0;
`ifdef SHIFTER_STATUS_EN
        r_carry <= 1'b0;
`endif
      end else begin
        if (flush) begin
          r_vld <= 1'b0;
        end else if (w_en[k]) begin
          r_vld <= w_src_vld;
        end
        // Payload only moves with a valid beat; a stalled stage holds its contents.
        if (w_en[k] && w_src_vld) begin
          r_data  <= w_shift_data;
          r_amt   <= w_src_amt >> 1;
          r_mode  <= w_src_mode;
`ifdef SHIFTER_STATUS_EN
          r_carry <= w_shift_carry;
`endif
        end
      end
    end

    assign w_vld[k]     = r_vld;
    assign w_q_data[k]  = r_data;
    assign w_q_amt[k]   = r_amt;
    assign w_q_mode[k]  = r_mode;
`ifdef SHIFTER_STATUS_EN
    assign w_q_carry[k] = r_carry;

    if (k == SHW - 1) begin : g_zero
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_zero <= 1'b0;
        end else if (w_en[k] && w_src_vld) begin
          r_zero <= (w_shift_data == '0);
        end
      end
    end
`endif
  end

  assign out_valid = w_vld[SHW-1];
  assign out_data  = w_q_data[SHW-1];
`ifdef SHIFTER_STATUS_EN
  assign out_zero  = r_zero;
  assign out_carry = w_q_carry[SHW-1];
`endif

  // The final stage's amount and mode have no consumer.
  logic w_unused;
  assign w_unused = ^{w_q_amt[SHW-1], w_q_mode[SHW-1]};

endmodule
